// File: rtl/vga_sync_ctrl_pkg.sv
// Shared VGA timing types and defaults: axis state encoding, 640x480 porch
// values and the coordinate width used by every counter in the raster path.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_FRONT  = 2'd1,
    ST_SYNC   = 2'd2,
    ST_BACK   = 2'd3
  } axis_state_e;

  localparam int COORD_W = 10;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FRONT_DEF  = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BACK_DEF   = 48;

  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FRONT_DEF  = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BACK_DEF   = 33;

  function automatic int axis_total(input int active, input int front,
                                    input int sync, input int back);
    return active + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_sync_ctrl_if.sv
// Raster timing bundle handed from the sync controller to the pixel pipeline.
interface vga_sync_ctrl_if;
  import vga_timing_pkg::*;

  logic               o_pix_en;
  logic               o_hsync;
  logic               o_vsync;
  logic               o_video_on;
  logic [COORD_W-1:0] o_x;
  logic [COORD_W-1:0] o_y;
  logic               o_frame_start;

  modport master (
    output o_pix_en, o_hsync, o_vsync, o_video_on, o_x, o_y, o_frame_start
  );

  modport slave (
    input o_pix_en, o_hsync, o_vsync, o_video_on, o_x, o_y, o_frame_start
  );

endinterface

// File: rtl/enable_gen.sv
// Free-running divider producing a one-clk strobe every 2^BIT_SIZE clocks.
module enable_gen #(
  parameter int BIT_SIZE = 2
) (
  input  logic clk,
  input  logic i_sclr,
  output logic o_en
);

  logic [BIT_SIZE-1:0] cnt;

  always_ff @(posedge clk) begin
    if (i_sclr) begin
      cnt  <= '0;
      o_en <= 1'b0;
    end else begin
      cnt  <= cnt + BIT_SIZE'(1);
      o_en <= &cnt;
    end
  end

endmodule

// File: rtl/vga_sync_ctrl_axis.sv
// One raster axis: position counter plus ACTIVE/FRONT/SYNC/BACK phase FSM,
// both advancing only on step and wrapping by explicit compare.
module vga_axis_ctr
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = H_ACTIVE_DEF,
  parameter int FRONT  = H_FRONT_DEF,
  parameter int SYNC   = H_SYNC_DEF,
  parameter int BACK   = H_BACK_DEF
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               step,
  output logic [COORD_W-1:0] cnt,
  output axis_state_e        state,
  output logic               wrap
);

  localparam int TOTAL = axis_total(ACTIVE, FRONT, SYNC, BACK);

  localparam logic [COORD_W-1:0] END_ACTIVE = COORD_W'(ACTIVE - 1);
  localparam logic [COORD_W-1:0] END_FRONT  = COORD_W'(ACTIVE + FRONT - 1);
  localparam logic [COORD_W-1:0] END_SYNC   = COORD_W'(ACTIVE + FRONT + SYNC - 1);
  localparam logic [COORD_W-1:0] END_BACK   = COORD_W'(TOTAL - 1);

  axis_state_e        state_q, state_d;
  logic [COORD_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ST_ACTIVE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (step) begin
      cnt_d = (cnt_q == END_BACK) ? '0 : cnt_q + COORD_W'(1);
      case (state_q)
        ST_ACTIVE: if (cnt_q == END_ACTIVE) state_d = ST_FRONT;
        ST_FRONT:  if (cnt_q == END_FRONT)  state_d = ST_SYNC;
        ST_SYNC:   if (cnt_q == END_SYNC)   state_d = ST_BACK;
        ST_BACK:   if (cnt_q == END_BACK)   state_d = ST_ACTIVE;
        default:                            state_d = ST_ACTIVE;
      endcase
    end
  end

  assign cnt   = cnt_q;
  assign state = state_q;
  assign wrap  = (cnt_q == END_BACK);

endmodule

// File: rtl/vga_sync_ctrl.sv
// VGA raster timing generator: pixel strobe divider feeding a horizontal and
// a line-end-gated vertical axis counter, with sync/blank/frame decode.
module vga_sync_ctrl
  import vga_timing_pkg::*;
#(
  parameter int   DIV_BITS = 2,
  parameter int   H_ACTIVE = H_ACTIVE_DEF,
  parameter int   H_FRONT  = H_FRONT_DEF,
  parameter int   H_SYNC   = H_SYNC_DEF,
  parameter int   H_BACK   = H_BACK_DEF,
  parameter int   V_ACTIVE = V_ACTIVE_DEF,
  parameter int   V_FRONT  = V_FRONT_DEF,
  parameter int   V_SYNC   = V_SYNC_DEF,
  parameter int   V_BACK   = V_BACK_DEF,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic            clk,
  input  logic            i_sclr,
  vga_sync_ctrl_if.master vga
);

  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_check
      $error("vga_sync_ctrl: H_TOTAL/V_TOTAL exceed 10-bit coordinate range");
    end
  endgenerate

  logic               pix_en;
  logic [COORD_W-1:0] h_cnt, v_cnt;
  axis_state_e        h_state, v_state;
  logic               h_wrap, v_wrap;
  logic               frame_start_q;

  enable_gen #(.BIT_SIZE(DIV_BITS)) u_enable_gen (
    .clk    (clk),
    .i_sclr (i_sclr),
    .o_en   (pix_en)
  );

  vga_axis_ctr #(
    .ACTIVE (H_ACTIVE), .FRONT (H_FRONT), .SYNC (H_SYNC), .BACK (H_BACK)
  ) u_h_axis (
    .clk   (clk),
    .clr   (i_sclr),
    .step  (pix_en),
    .cnt   (h_cnt),
    .state (h_state),
    .wrap  (h_wrap)
  );

  // Vertical axis only moves on the strobe that closes a line.
  vga_axis_ctr #(
    .ACTIVE (V_ACTIVE), .FRONT (V_FRONT), .SYNC (V_SYNC), .BACK (V_BACK)
  ) u_v_axis (
    .clk   (clk),
    .clr   (i_sclr),
    .step  (pix_en & h_wrap),
    .cnt   (v_cnt),
    .state (v_state),
    .wrap  (v_wrap)
  );

  // Raised on the same edge that wraps both counters, so it lines up with (0,0).
  always_ff @(posedge clk) begin
    if (i_sclr) frame_start_q <= 1'b0;
    else        frame_start_q <= pix_en & h_wrap & v_wrap;
  end

  assign vga.o_pix_en      = pix_en;
  assign vga.o_x           = h_cnt;
  assign vga.o_y           = v_cnt;
  assign vga.o_hsync       = (h_state == ST_SYNC) ? SYNC_POL : ~SYNC_POL;
  assign vga.o_vsync       = (v_state == ST_SYNC) ? SYNC_POL : ~SYNC_POL;
  assign vga.o_video_on    = (h_state == ST_ACTIVE) && (v_state == ST_ACTIVE);
  assign vga.o_frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_ctrl.sv
// Directed bench for vga_sync_ctrl on a tiny 8x6 raster with a /2 pixel strobe.
module tb_vga_sync_ctrl;

  logic clk = 1'b0;
  logic i_sclr = 1'b1;
  int   errs = 0;
  int   checks = 0;

  vga_sync_ctrl_if vif ();

  vga_sync_ctrl #(
    .DIV_BITS (1),
    .H_ACTIVE (4), .H_FRONT (1), .H_SYNC (2), .H_BACK (1),
    .V_ACTIVE (3), .V_FRONT (1), .V_SYNC (1), .V_BACK (1),
    .SYNC_POL (1'b0)
  ) dut (
    .clk    (clk),
    .i_sclr (i_sclr),
    .vga    (vif)
  );

  always #5 clk = ~clk;

  // Returns at the falling edge right after the posedge that consumed a strobe.
  task automatic strobe();
    int n = 0;
    while (vif.o_pix_en !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (n == 8) begin
      checks++; errs++;
      $display("FAIL strobe_timeout: pix_en=%b after %0d clk, need 1", vif.o_pix_en, n);
    end
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    checks++;
    if (vif.o_x !== 10'd0 || vif.o_y !== 10'd0 || vif.o_video_on !== 1'b1 ||
        vif.o_hsync !== 1'b1 || vif.o_vsync !== 1'b1 || vif.o_frame_start !== 1'b0) begin
      errs++;
      $display("FAIL %s: x=%0d y=%0d von=%b hs=%b vs=%b fs=%b, need x=0 y=0 von=1 hs=1 vs=1 fs=0",
               tag, vif.o_x, vif.o_y, vif.o_video_on, vif.o_hsync, vif.o_vsync,
               vif.o_frame_start);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_sclr = 1'b1;
    @(negedge clk);
    i_sclr = 1'b0;
  endtask

  task automatic test_reset();
    i_sclr = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("reset_held");
    checks++;
    if (vif.o_pix_en !== 1'b0) begin
      errs++; $display("FAIL reset_pix_en: got %b need 0", vif.o_pix_en);
    end
    i_sclr = 1'b0;
    @(negedge clk);
    check_reset_vals("reset_first_cycle");
    @(negedge clk);
    check_reset_vals("reset_hold_to_strobe");
    checks++;
    if (vif.o_pix_en !== 1'b1) begin
      errs++; $display("FAIL reset_first_strobe: pix_en=%b need 1", vif.o_pix_en);
    end
  endtask

  task automatic test_line_sweep();
    logic [9:0] ex  [8] = '{10'd1, 10'd2, 10'd3, 10'd4, 10'd5, 10'd6, 10'd7, 10'd0};
    logic [9:0] ey  [8] = '{10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd1};
    logic       evo [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       ehs [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 8; k++) begin
      strobe();
      checks++;
      if (vif.o_x !== ex[k] || vif.o_y !== ey[k] || vif.o_video_on !== evo[k] ||
          vif.o_hsync !== ehs[k] || vif.o_vsync !== 1'b1) begin
        errs++;
        $display("FAIL line_sweep_s%0d: x=%0d y=%0d von=%b hs=%b vs=%b, need x=%0d y=%0d von=%b hs=%b vs=1",
                 k + 1, vif.o_x, vif.o_y, vif.o_video_on, vif.o_hsync, vif.o_vsync,
                 ex[k], ey[k], evo[k], ehs[k]);
      end
    end
  endtask

  task automatic test_strobe_spacing();
    logic       prev_pen = vif.o_pix_en;
    logic [9:0] prev_x   = vif.o_x;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      checks++;
      if (vif.o_pix_en !== ~prev_pen) begin
        errs++;
        $display("FAIL strobe_spacing_c%0d: pix_en=%b need %b", c, vif.o_pix_en, ~prev_pen);
      end
      checks++;
      if (!prev_pen && vif.o_x !== prev_x) begin
        errs++;
        $display("FAIL x_hold_c%0d: x=%0d need %0d (no strobe)", c, vif.o_x, prev_x);
      end
      prev_pen = vif.o_pix_en;
      prev_x   = vif.o_x;
    end
  endtask

  task automatic test_frame();
    int vlow = 0;
    int n;
    do_reset();
    for (int k = 1; k <= 48; k++) begin
      logic [9:0] ex = 10'(k % 8);
      logic [9:0] ey = 10'((k / 8) % 6);
      strobe();
      if (vif.o_vsync === 1'b0) vlow++;
      checks++;
      if (vif.o_x !== ex || vif.o_y !== ey || vif.o_vsync !== (ey != 10'd4) ||
          vif.o_frame_start !== (k == 48)) begin
        errs++;
        $display("FAIL frame_s%0d: x=%0d y=%0d vs=%b fs=%b, need x=%0d y=%0d vs=%b fs=%b",
                 k, vif.o_x, vif.o_y, vif.o_vsync, vif.o_frame_start,
                 ex, ey, (ey != 10'd4), (k == 48));
      end
    end
    checks++;
    if (vlow != 8) begin
      errs++; $display("FAIL vsync_width: low for %0d strobes, need 8", vlow);
    end
    @(negedge clk);
    checks++;
    if (vif.o_frame_start !== 1'b0) begin
      errs++; $display("FAIL frame_start_width: fs=%b one clk later, need 0", vif.o_frame_start);
    end
    n = 1;
    while (vif.o_frame_start !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 96) begin
      errs++; $display("FAIL frame_period: next pulse after %0d clk, need 96", n);
    end
  endtask

  task automatic test_midframe_reset();
    do_reset();
    repeat (37) strobe();
    checks++;
    if (vif.o_x !== 10'd5 || vif.o_y !== 10'd4 || vif.o_hsync !== 1'b0 || vif.o_vsync !== 1'b0) begin
      errs++;
      $display("FAIL midframe_pos: x=%0d y=%0d hs=%b vs=%b, need x=5 y=4 hs=0 vs=0",
               vif.o_x, vif.o_y, vif.o_hsync, vif.o_vsync);
    end
    @(negedge clk);
    checks++;
    if (vif.o_pix_en !== 1'b1) begin
      errs++; $display("FAIL midframe_strobe: pix_en=%b need 1", vif.o_pix_en);
    end
    i_sclr = 1'b1;
    @(negedge clk);
    check_reset_vals("midframe_reset");
    i_sclr = 1'b0;
    strobe();
    checks++;
    if (vif.o_x !== 10'd1 || vif.o_y !== 10'd0 || vif.o_video_on !== 1'b1) begin
      errs++;
      $display("FAIL midframe_restart: x=%0d y=%0d von=%b, need x=1 y=0 von=1",
               vif.o_x, vif.o_y, vif.o_video_on);
    end
  endtask

  initial begin
    test_reset();
    test_line_sweep();
    test_strobe_spacing();
    test_frame();
    test_midframe_reset();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/vga_sync_ctrl.md
# vga_sync_ctrl

Sequences VGA horizontal/vertical raster timing from a divided pixel enable. It instantiates `enable_gen` to derive the pixel-rate strobe from the system clock. It steps two counter/FSM pairs (horizontal, vertical) once per strobe and drives sync, blanking, pixel coordinates and a frame-start pulse. It sits between the clock/reset domain and the pixel-generation pipeline, which consumes `o_pix_en`, `o_x`, `o_y` and `o_video_on`.

## Interface
- `DIV_BITS`, 2, pixel strobe period = 2^DIV_BITS clk cycles (passed to `enable_gen` as BIT_SIZE).
- `H_ACTIVE`, 640, visible pixels per line.
- `H_FRONT`, 16, horizontal front porch (pixels).
- `H_SYNC`, 96, hsync width (pixels).
- `H_BACK`, 48, horizontal back porch (pixels).
- `V_ACTIVE`, 480, visible lines.
- `V_FRONT`, 10, vertical front porch (lines).
- `V_SYNC`, 2, vsync width (lines).
- `V_BACK`, 33, vertical back porch (lines).
- `SYNC_POL`, 0, asserted sync level (0 = active-low).

Ports:
- `clk` in 1: single system clock; all logic on rising edge.
- `i_sclr` in 1: reset; synchronous, active-high.
- `o_pix_en` out 1: pixel strobe from `enable_gen`, one clk wide.
- `o_hsync` out 1: horizontal sync, level per SYNC_POL.
- `o_vsync` out 1: vertical sync, level per SYNC_POL.
- `o_video_on` out 1: high while both axes are in ACTIVE.
- `o_x` out 10: horizontal counter, 0..H_TOTAL-1.
- `o_y` out 10: vertical counter, 0..V_TOTAL-1.
- `o_frame_start` out 1: one-clk pulse when raster returns to (0,0).

## Operation
- H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK. V_TOTAL is the analogous sum. Both totals must be ≤ 1024; violations are an elaboration error.
- Per-axis FSM, 2-bit state: ACTIVE → FRONT → SYNC → BACK → ACTIVE.
- Horizontal transitions, each taken on a strobe:
  - ACTIVE→FRONT when h_cnt = H_ACTIVE-1.
  - FRONT→SYNC at H_ACTIVE+H_FRONT-1.
  - SYNC→BACK at H_ACTIVE+H_FRONT+H_SYNC-1.
  - BACK→ACTIVE at H_TOTAL-1, where h_cnt wraps to 0.
- Vertical axis uses the same rule with V_* parameters. It advances only on a strobe where h_cnt = H_TOTAL-1 (line end).
- The cycle with h wrap and v = V_TOTAL-1 wraps both counters to 0 and sets `o_frame_start` for the following cycle.
- `o_hsync` = SYNC_POL while h state is SYNC, else ~SYNC_POL. `o_vsync` follows the same rule on the v state.
- Counters are unsigned, width 10. Wrap is by explicit compare to TOTAL-1, never by natural overflow.
- Reset values, held while `i_sclr`=1 and in the first cycle after:
  - o_x=0, o_y=0, both FSMs ACTIVE.
  - o_video_on=1, o_hsync=o_vsync=~SYNC_POL.
  - o_frame_start=0.
  - `enable_gen` cleared by the same `i_sclr`.
- Reset mid-frame: the next clk returns everything to the reset values, with no partial sync pulse retained.
- Reset asserted on a strobe cycle: reset wins and the advance is discarded.

## Timing
- All outputs except `o_pix_en` are registered and change only in the clk cycle after a strobe.
- Latency from strobe to updated outputs is 1 clk.
- `o_pix_en` is combinational pass-through of `enable_gen.o_en`.
- Between strobes, all outputs hold their values.
- Sync, blanking and coordinates are mutually consistent in every cycle, with no skew between outputs.
- `o_frame_start` is high for exactly 1 clk per frame, coincident with o_x=0, o_y=0.
- Pixel period = 2^DIV_BITS clk. Line = H_TOTAL strobes. Frame = H_TOTAL×V_TOTAL strobes.

## Structure
- Package `vga_timing_pkg` holds:
  - the axis state enum (ACTIVE, FRONT, SYNC, BACK, 2 bits);
  - default 640×480 timing constants;
  - the 10-bit coordinate width constant.
- One sub-module, `vga_axis_ctr`, implements one counter plus FSM (params ACTIVE/FRONT/SYNC/BACK; inputs step, clr; outputs cnt, state, wrap). It is instantiated twice:
  - horizontal: step = `o_pix_en`;
  - vertical: step = `o_pix_en` & h wrap.
- `enable_gen` is reused unmodified.

## Test plan
Bench parameters: DIV_BITS=1, H=4/1/2/1 (H_TOTAL=8), V=3/1/1/1 (V_TOTAL=6), SYNC_POL=0.
- Reset: hold `i_sclr` 3 clk, release → o_x=0, o_y=0, o_video_on=1, o_hsync=1, o_vsync=1, o_frame_start=0; values hold until the first strobe.
- Line sweep: count strobes after reset.
  - After strobes 1–3, o_x = 1,2,3 with o_video_on=1.
  - After strobe 4, o_x=4 and o_video_on=0.
  - After strobes 5–6, o_x = 5,6 with o_hsync=0.
  - After strobe 7, o_x=7 and o_hsync=1.
  - After strobe 8, o_x=0 and o_y=1.
- Strobe spacing: `o_pix_en` pulses exactly every 2 clk. o_x never changes in a cycle not immediately following a strobe.
- Vertical/frame: o_vsync=0 exactly while o_y=4 (8 strobes). After strobe 48, o_x=0, o_y=0 and o_frame_start=1 for 1 clk. The pulse repeats every 96 clk.
- Mid-frame reset: assert `i_sclr` at o_x=5, o_y=4 (hsync and vsync both low) → next clk all outputs at reset values. Counting restarts from (0,0).
